rom_decoder_arbiter: RTL and testbench
======================================

Name: rom_decoder_arbiter

Overview:
- Shares one synchronous 512x8 decoder ROM between two requesters, port A and port B.
- The ROM has 1-cycle registered read latency and a clock enable.
- The block arbitrates requests, drives the ROM address and clock enable, and tracks which port owns each in-flight read.
- It returns each read's data to the owning port with a valid pulse.

Parameters:
- ADDRESS_WIDTH, 9: ROM address width.
- DATA_WIDTH, 8: ROM data width.
- PRIORITY_MODE, 0: 0 = round-robin between A and B; 1 = fixed priority, A wins.

Ports:
- clock_i  input  1  system clock.
- reset_i  input  1  synchronous, active-high reset.
- pause_i  input  1  while high, no new grants are issued; in-flight reads still complete.
- req_a_i  input  1  port A request; held high until ack_a_o is seen.
- address_a_i  input  ADDRESS_WIDTH  port A address; stable while req_a_i is high.
- ack_a_o  output  1  one-cycle pulse: port A request accepted.
- data_a_o  output  DATA_WIDTH  port A read data; holds last value.
- valid_a_o  output  1  one-cycle pulse: data_a_o updated.
- req_b_i, address_b_i, ack_b_o, data_b_o, valid_b_o: same as port A, for port B.
- rom_clock_enable_o  output  1  ROM clock enable.
- rom_address_o  output  ADDRESS_WIDTH  ROM address.
- rom_data_i  input  DATA_WIDTH  ROM data, valid 1 cycle after an enabled edge.

Behaviour:
- Single clock domain: clock_i. Reset is synchronous and active-high on reset_i.
- All outputs are registered.
- Reset values:
  - ack_*, valid_*, rom_clock_enable_o = 0.
  - data_*, rom_address_o = 0.
  - Round-robin pointer last_grant = B, so A wins the first contention.
  - Tag pipeline cleared.
- Eligibility: port X is eligible in a cycle iff req_x_i = 1 and ack_x_o = 0 in that cycle.
  - The ack cycle is the requester's handshake cycle; its req is still high then and must not be regranted.
  - A single port therefore gets at most one grant every 2 cycles.
  - Alternating A/B can issue a grant every cycle.
- Arbitration at each clock edge, when pause_i = 0 and at least one port is eligible:
  - Only one port eligible: grant it.
  - Both eligible, PRIORITY_MODE = 0: grant the port that is not last_grant.
  - Both eligible, PRIORITY_MODE = 1: grant A.
  - Effects on that edge: ack_x_o <= 1; rom_address_o <= address_x_i; rom_clock_enable_o <= 1; issue tag <= {1, X}; last_grant <= X.
- No grant on an edge: ack_* <= 0, rom_clock_enable_o <= 0, issue tag valid <= 0, rom_address_o holds.
- Pipeline timing (N = cycle in which the request is first eligible and wins):
  - N+1: ack and ROM enable high; ROM captures the address at the end of N+1.
  - N+2: rom_data_i is valid; return tag <= issue tag.
  - End of N+2: if return tag valid, data_X_o <= rom_data_i and valid_X_o <= 1 for one cycle.
  - Data is visible in N+3. Request-to-valid latency is 3 cycles. Throughput is 1 read/cycle aggregate.
- valid_a_o and valid_b_o are never high in the same cycle.
- data_x_o changes only on its own valid.
- Reads are returned in issue order; no reordering.
- pause_i high:
  - Blocks new grants from that edge on.
  - Already-issued reads still produce valid pulses.
  - Requests stay pending and are granted the cycle after pause_i falls.
- Request dropped before ack: the requester-protocol violation is tolerated; eligibility is sampled each cycle, so it is simply not granted.
- Reset mid-operation: in-flight reads are discarded and no valid pulse is produced for them; the outputs return to their reset values.
- Address changed while req is high and unacked: the address captured is the one present on the granting edge.

Test Plan:
Common bench setup: the ROM model returns mem[a] = a[7:0] ^ 8'hA5.
- Reset, then A alone requests addr 9'h012 in cycle 0 → ack_a_o high in cycle 1; rom_address_o = 9'h012 with enable in cycle 1; valid_a_o high in cycle 3 with data_a_o = 8'hB7; valid_b_o stays 0.
- A and B request together (A: 9'h100, B: 9'h0FF), both holding req until ack, PRIORITY_MODE = 0 → A acked cycle 1, B acked cycle 2; valid_a cycle 3 with data 8'hA5, valid_b cycle 4 with data 8'h5A.
- Both hold req continuously for 8 cycles with new addresses after each ack, round-robin → grants strictly alternate A,B,A,B...; rom_clock_enable_o high every cycle after the first; every response is returned to the correct port, in issue order.
- Same continuous load with PRIORITY_MODE = 1 → A is granted every other cycle, and B is granted only in A's ack cycles, when A is ineligible.
- pause_i raised in the cycle after A's ack, with B requesting → A's read completes (valid_a pulse); no ack_b while paused; ack_b_o high 1 cycle after pause_i falls, then valid_b 2 cycles later.
- reset_i pulsed 1 cycle after ack_a_o → no valid_a_o pulse; all outputs 0 on the next cycle; a fresh request afterwards behaves as in the first scenario.

Source files
------------

// File: rtl/rom_decoder_arbiter.sv
// Two-port arbiter sharing a 1-cycle-latency synchronous decoder ROM.
// Grant at edge N, ROM enabled in N+1, data returned with a valid pulse in N+3.
module rom_decoder_arbiter #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     pause_i,

  input  logic                     req_a_i,
  input  logic [ADDRESS_WIDTH-1:0] address_a_i,
  output logic                     ack_a_o,
  output logic [DATA_WIDTH-1:0]    data_a_o,
  output logic                     valid_a_o,

  input  logic                     req_b_i,
  input  logic [ADDRESS_WIDTH-1:0] address_b_i,
  output logic                     ack_b_o,
  output logic [DATA_WIDTH-1:0]    data_b_o,
  output logic                     valid_b_o,

  output logic                     rom_clock_enable_o,
  output logic [ADDRESS_WIDTH-1:0] rom_address_o,
  input  logic [DATA_WIDTH-1:0]    rom_data_i
);

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic vld;
    logic port;
  } tag_t;

  logic                     r_ack_a;
  logic                     r_ack_b;
  logic                     r_valid_a;
  logic                     r_valid_b;
  logic [DATA_WIDTH-1:0]    r_data_a;
  logic [DATA_WIDTH-1:0]    r_data_b;
  logic                     r_rom_ce;
  logic [ADDRESS_WIDTH-1:0] r_rom_addr;
  logic                     r_last_grant;
  tag_t                     r_issue_tag;
  tag_t                     r_ret_tag;

  logic                     w_elig_a;
  logic                     w_elig_b;
  logic                     w_grant;
  logic                     w_grant_port;
  logic [ADDRESS_WIDTH-1:0] w_grant_addr;

  // The ack cycle is the requester's handshake: its req is still high then.
  assign w_elig_a = req_a_i & ~r_ack_a;
  assign w_elig_b = req_b_i & ~r_ack_b;

  always_comb begin
    w_grant      = 1'b0;
    w_grant_port = PORT_A;
    if (!pause_i) begin
      if (w_elig_a && w_elig_b) begin
        w_grant = 1'b1;
        if (PRIORITY_MODE != 0) begin
          w_grant_port = PORT_A;
        end else begin
          w_grant_port = ~r_last_grant;
        end
      end else if (w_elig_a) begin
        w_grant      = 1'b1;
        w_grant_port = PORT_A;
      end else if (w_elig_b) begin
        w_grant      = 1'b1;
        w_grant_port = PORT_B;
      end
    end
  end

  assign w_grant_addr = (w_grant_port == PORT_B) ? address_b_i : address_a_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_ack_a          <= 1'b0;
      r_ack_b          <= 1'b0;
      r_valid_a        <= 1'b0;
      r_valid_b        <= 1'b0;
      r_data_a         <= '0;
      r_data_b         <= '0;
      r_rom_ce         <= 1'b0;
      r_rom_addr       <= '0;
      r_last_grant     <= PORT_B;
      r_issue_tag.vld  <= 1'b0;
      r_issue_tag.port <= PORT_A;
      r_ret_tag.vld    <= 1'b0;
      r_ret_tag.port   <= PORT_A;
    end else begin
      r_ack_a          <= w_grant && (w_grant_port == PORT_A);
      r_ack_b          <= w_grant && (w_grant_port == PORT_B);
      r_rom_ce         <= w_grant;
      r_issue_tag.vld  <= w_grant;
      r_issue_tag.port <= w_grant_port;
      if (w_grant) begin
        r_rom_addr   <= w_grant_addr;
        r_last_grant <= w_grant_port;
      end

      // Tag travels alongside the ROM's one-cycle read latency.
      r_ret_tag <= r_issue_tag;

      r_valid_a <= r_ret_tag.vld && (r_ret_tag.port == PORT_A);
      r_valid_b <= r_ret_tag.vld && (r_ret_tag.port == PORT_B);
      if (r_ret_tag.vld && (r_ret_tag.port == PORT_A)) begin
        r_data_a <= rom_data_i;
      end
      if (r_ret_tag.vld && (r_ret_tag.port == PORT_B)) begin
        r_data_b <= rom_data_i;
      end
    end
  end

  assign ack_a_o            = r_ack_a;
  assign ack_b_o            = r_ack_b;
  assign valid_a_o          = r_valid_a;
  assign valid_b_o          = r_valid_b;
  assign data_a_o           = r_data_a;
  assign data_b_o           = r_data_b;
  assign rom_clock_enable_o = r_rom_ce;
  assign rom_address_o      = r_rom_addr;

endmodule

// File: tb/tb_rom_decoder_arbiter.sv
// Bench for rom_decoder_arbiter: a round-robin DUT (0) and a fixed-priority DUT (1)
// driven by independent hold-until-ack requesters; acks and valids checked against queues.
module tb_rom_decoder_arbiter;

  typedef struct packed {
    int         cyc;
    logic [8:0] val;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic pause;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // Requester index r: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
  logic [3:0] req;
  logic [8:0] addr [4];

  logic       ack_a0, ack_b0, val_a0, val_b0, ce0;
  logic       ack_a1, ack_b1, val_a1, val_b1, ce1;
  logic [7:0] data_a0, data_b0, data_a1, data_b1;
  logic [8:0] raddr0, raddr1;
  logic [7:0] rom_q0 = 8'h00;
  logic [7:0] rom_q1 = 8'h00;

  logic [3:0] ack;
  logic [3:0] vld;
  logic [7:0] dat [4];
  logic [1:0] ce;
  logic [8:0] raddr [2];

  assign ack      = {ack_b1, ack_a1, ack_b0, ack_a0};
  assign vld      = {val_b1, val_a1, val_b0, val_a0};
  assign dat[0]   = data_a0;
  assign dat[1]   = data_b0;
  assign dat[2]   = data_a1;
  assign dat[3]   = data_b1;
  assign ce       = {ce1, ce0};
  assign raddr[0] = raddr0;
  assign raddr[1] = raddr1;

  rom_decoder_arbiter #(.ADDRESS_WIDTH(9), .DATA_WIDTH(8), .PRIORITY_MODE(0)) dut0 (
    .clock_i(clk), .reset_i(rst), .pause_i(pause),
    .req_a_i(req[0]), .address_a_i(addr[0]), .ack_a_o(ack_a0), .data_a_o(data_a0), .valid_a_o(val_a0),
    .req_b_i(req[1]), .address_b_i(addr[1]), .ack_b_o(ack_b0), .data_b_o(data_b0), .valid_b_o(val_b0),
    .rom_clock_enable_o(ce0), .rom_address_o(raddr0), .rom_data_i(rom_q0)
  );

  rom_decoder_arbiter #(.ADDRESS_WIDTH(9), .DATA_WIDTH(8), .PRIORITY_MODE(1)) dut1 (
    .clock_i(clk), .reset_i(rst), .pause_i(pause),
    .req_a_i(req[2]), .address_a_i(addr[2]), .ack_a_o(ack_a1), .data_a_o(data_a1), .valid_a_o(val_a1),
    .req_b_i(req[3]), .address_b_i(addr[3]), .ack_b_o(ack_b1), .data_b_o(data_b1), .valid_b_o(val_b1),
    .rom_clock_enable_o(ce1), .rom_address_o(raddr1), .rom_data_i(rom_q1)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: mem[a] = a[7:0] ^ 8'hA5, registered on enabled edges.
  always @(posedge clk) begin
    if (ce0) rom_q0 <= raddr0[7:0] ^ 8'hA5;
    if (ce1) rom_q1 <= raddr1[7:0] ^ 8'hA5;
  end

  // Requester lists and driver state.
  logic [8:0] alist [4][16];
  int         alen [4];
  int         aidx [4];
  int         st [4];
  bit         pend [4];

  initial begin
    req = '0;
    for (int r = 0; r < 4; r++) begin
      addr[r] = '0;
      alen[r] = 0;
      aidx[r] = 0;
      st[r]   = 0;
      pend[r] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int r = 0; r < 4; r++) begin
        if (req[r] && pend[r]) begin
          aidx[r] = aidx[r] + 1;
          if (aidx[r] < alen[r]) addr[r] = alist[r][aidx[r]];
          else req[r] = 1'b0;
        end else if (!req[r] && aidx[r] < alen[r] && cyc >= st[r]) begin
          req[r]  = 1'b1;
          addr[r] = alist[r][aidx[r]];
        end
        pend[r] = ack[r];
      end
    end
  end

  // Scoreboard queues.
  ent_t ackq [4][$];
  ent_t valq [4][$];

  task automatic exp(input int r, input int ac, input logic [8:0] a,
                     input logic [7:0] d, input bit with_valid);
    ent_t e;
    e.cyc = ac;
    e.val = a;
    ackq[r].push_back(e);
    if (with_valid) begin
      e.cyc = ac + 2;
      e.val = {1'b0, d};
      valq[r].push_back(e);
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an ack or valid.
  logic [7:0] prevd [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic       prev_rst = 1'b1;

  always @(negedge clk) begin
    ent_t e;
    for (int r = 0; r < 4; r++) begin
      if (ack[r]) begin
        total++;
        if (ackq[r].size() == 0) begin
          bad++;
          $display("FAIL ack_unexpected[%0d]: got ack at cycle %0d want none", r, cyc);
        end else begin
          e = ackq[r].pop_front();
          if (e.cyc != cyc || raddr[r/2] != e.val || !ce[r/2]) begin
            bad++;
            $display("FAIL ack[%0d]: got cyc=%0d addr=%0h ce=%0b want cyc=%0d addr=%0h ce=1",
                     r, cyc, raddr[r/2], ce[r/2], e.cyc, e.val);
          end
        end
      end
      if (vld[r]) begin
        total++;
        if (valq[r].size() == 0) begin
          bad++;
          $display("FAIL valid_unexpected[%0d]: got valid at cycle %0d want none", r, cyc);
        end else begin
          e = valq[r].pop_front();
          if (e.cyc != cyc || dat[r] != e.val[7:0]) begin
            bad++;
            $display("FAIL valid[%0d]: got cyc=%0d data=%0h want cyc=%0d data=%0h",
                     r, cyc, dat[r], e.cyc, e.val[7:0]);
          end
        end
      end
      if (!prev_rst && dat[r] != prevd[r]) begin
        total++;
        if (!vld[r]) begin
          bad++;
          $display("FAIL data_hold[%0d]: got %0h without valid want %0h", r, dat[r], prevd[r]);
        end
      end
      prevd[r] = dat[r];
    end
    for (int d = 0; d < 2; d++) begin
      if (vld[2*d] || vld[2*d+1]) begin
        total++;
        if (vld[2*d] && vld[2*d+1]) begin
          bad++;
          $display("FAIL valid_excl[%0d]: got both valids want one", d);
        end
      end
    end
    prev_rst = rst;
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_lists(input int s);
    for (int r = 0; r < 4; r++) begin
      alen[r] = 0;
      aidx[r] = 0;
      st[r]   = s;
    end
  endtask

  task automatic add(input int r, input logic [8:0] a);
    alist[r][alen[r]] = a;
    alen[r] = alen[r] + 1;
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_d0"}, {ack_a0, ack_b0, val_a0, val_b0, ce0, data_a0, data_b0, raddr0}, 64'h0);
    check({nm, "_d1"}, {ack_a1, ack_b1, val_a1, val_b1, ce1, data_a1, data_b1, raddr1}, 64'h0);
  endtask

  int s;

  initial begin
    rst   = 1'b1;
    pause = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    check_idle("reset_state");

    // A alone, fresh after reset.
    s = cyc + 1;
    clear_lists(s);
    add(0, 9'h012); add(2, 9'h012);
    exp(0, s+1, 9'h012, 8'hB7, 1); exp(2, s+1, 9'h012, 8'hB7, 1);
    wait_to(s + 6);

    // Contention with last_grant = A: round-robin picks B, fixed priority picks A.
    s = cyc + 1;
    clear_lists(s);
    add(0, 9'h1AB); add(1, 9'h033); add(2, 9'h1AB); add(3, 9'h033);
    exp(1, s+1, 9'h033, 8'h96, 1); exp(0, s+2, 9'h1AB, 8'h0E, 1);
    exp(2, s+1, 9'h1AB, 8'h0E, 1); exp(3, s+2, 9'h033, 8'h96, 1);
    wait_to(s + 7);

    // Reset, then simultaneous A/B: A first in both modes.
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    s = cyc + 1;
    clear_lists(s);
    add(0, 9'h100); add(1, 9'h0FF); add(2, 9'h100); add(3, 9'h0FF);
    for (int d = 0; d < 2; d++) begin
      exp(2*d, s+1, 9'h100, 8'hA5, 1);
      exp(2*d+1, s+2, 9'h0FF, 8'h5A, 1);
    end
    wait_to(s + 7);

    // Continuous load: strict alternation A,B,A,B and enable every cycle.
    s = cyc + 1;
    clear_lists(s);
    for (int d = 0; d < 2; d++) begin
      add(2*d, 9'h001); add(2*d, 9'h0F0); add(2*d, 9'h155); add(2*d, 9'h1FF);
      add(2*d+1, 9'h002); add(2*d+1, 9'h0AA); add(2*d+1, 9'h17E); add(2*d+1, 9'h080);
      exp(2*d, s+1, 9'h001, 8'hA4, 1); exp(2*d+1, s+2, 9'h002, 8'hA7, 1);
      exp(2*d, s+3, 9'h0F0, 8'h55, 1); exp(2*d+1, s+4, 9'h0AA, 8'h0F, 1);
      exp(2*d, s+5, 9'h155, 8'hF0, 1); exp(2*d+1, s+6, 9'h17E, 8'hDB, 1);
      exp(2*d, s+7, 9'h1FF, 8'h5A, 1); exp(2*d+1, s+8, 9'h080, 8'h25, 1);
    end
    for (int k = 1; k <= 8; k++) begin
      wait_to(s + k);
      check("ce_busy_d0", ce0, 1);
      check("ce_busy_d1", ce1, 1);
    end
    wait_to(s + 9);
    check("ce_drain_d0", ce0, 0);
    check("ce_drain_d1", ce1, 0);
    wait_to(s + 13);

    // Pause after A's ack while B waits: A completes, B granted once pause falls.
    s = cyc + 1;
    clear_lists(s);
    st[1] = s + 2;
    st[3] = s + 2;
    add(0, 9'h0C3); add(1, 9'h05A); add(2, 9'h0C3); add(3, 9'h05A);
    for (int d = 0; d < 2; d++) begin
      exp(2*d, s+1, 9'h0C3, 8'h66, 1);
      exp(2*d+1, s+7, 9'h05A, 8'hFF, 1);
    end
    wait_to(s + 2);
    pause = 1'b1;
    wait_to(s + 6);
    pause = 1'b0;
    wait_to(s + 12);

    // Reset one cycle after ack: in-flight read must be dropped.
    s = cyc + 1;
    clear_lists(s);
    add(0, 9'h044); add(2, 9'h044);
    exp(0, s+1, 9'h044, 8'h00, 0); exp(2, s+1, 9'h044, 8'h00, 0);
    wait_to(s + 2);
    rst = 1'b1;
    wait_to(s + 3);
    rst = 1'b0;
    check_idle("midreset_state");
    wait_to(s + 6);

    // Fresh request after reset behaves like the first one.
    s = cyc + 1;
    clear_lists(s);
    add(0, 9'h012); add(2, 9'h012);
    exp(0, s+1, 9'h012, 8'hB7, 1); exp(2, s+1, 9'h012, 8'hB7, 1);
    wait_to(s + 8);

    for (int r = 0; r < 4; r++) begin
      check($sformatf("ack_left[%0d]", r), ackq[r].size(), 0);
      check($sformatf("valid_left[%0d]", r), valq[r].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
